cond_flags_unit: RTL and testbench

// Execute-stage condition unit for the pipelined core, successor to the combinational condition check.

---
 rtl/cond_flags_unit.sv | 160 ++++++++++++++++
 tb/tb_cond_flags_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cond_flags_unit.sv
// Execute-stage condition unit: owns the NZCV + sticky flags register,
// evaluates instruction conditions, forwards next-flags and sequences IT blocks.
module cond_flags_unit #(
    parameter int unsigned NFLAGS = 5,
    parameter int unsigned IT_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              Valid,
    input  logic [3:0]        Cond,
    input  logic [NFLAGS-1:0] ALUFlags,
    input  logic [2:0]        FlagsWrite,
    input  logic              ITStart,
    input  logic [3:0]        ITCond,
    input  logic [IT_MAX-1:0] ITMask,
    input  logic [2:0]        ITLen,
    output logic              CondEx,
    output logic [NFLAGS-1:0] FlagsNext,
    output logic [NFLAGS-1:0] Flags,
    output logic              InIT,
    output logic [2:0]        ITRemain,
    output logic              ITErr
);

    localparam int unsigned NSTICKY = NFLAGS - 4;
    localparam int unsigned IDX_N   = NFLAGS - 1;
    localparam int unsigned IDX_Z   = NFLAGS - 2;
    localparam int unsigned IDX_C   = NFLAGS - 3;
    localparam int unsigned IDX_V   = NFLAGS - 4;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        itcond_q, itcond_d;
    logic [IT_MAX-1:0] mask_q, mask_d;
    logic [2:0]        remain_d;
    logic              iterr_d;
    logic [3:0]        eff_cond;
    logic              accept;
    logic              len_ok;

    // Condition-code evaluation against the N, Z, C, V flags.
    function automatic logic cond_eval(input logic [3:0] c, input logic n,
                                       input logic z, input logic cf, input logic v);
        logic r;
        case (c)
            4'd0:    r = z;
            4'd1:    r = ~z;
            4'd2:    r = cf;
            4'd3:    r = ~cf;
            4'd4:    r = n;
            4'd5:    r = ~n;
            4'd6:    r = v;
            4'd7:    r = ~v;
            4'd8:    r = cf & ~z;
            4'd9:    r = ~cf | z;
            4'd10:   r = (n == v);
            4'd11:   r = (n != v);
            4'd12:   r = ~z & (n == v);
            4'd13:   r = z | (n != v);
            4'd14:   r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign InIT     = (state_q == ACTIVE);
    assign eff_cond = InIT ? (itcond_q ^ {3'b000, ~mask_q[0]}) : Cond;
    assign accept   = Valid & ~Stall & ~Flush;
    assign len_ok   = (ITLen != 3'd0) && (ITLen <= 3'(IT_MAX));

    // Zero-latency execute decision and grouped next-flags forward.
    always_comb begin
        CondEx    = Valid & ~Flush & cond_eval(eff_cond, Flags[IDX_N], Flags[IDX_Z],
                                               Flags[IDX_C], Flags[IDX_V]);
        FlagsNext = Flags;
        if (CondEx && FlagsWrite[2]) begin
            FlagsNext[IDX_N] = ALUFlags[IDX_N];
            FlagsNext[IDX_Z] = ALUFlags[IDX_Z];
        end
        if (CondEx && FlagsWrite[1]) begin
            FlagsNext[IDX_C] = ALUFlags[IDX_C];
            FlagsNext[IDX_V] = ALUFlags[IDX_V];
        end
        if (CondEx && FlagsWrite[0]) begin
            FlagsNext[NSTICKY-1:0] = Flags[NSTICKY-1:0] | ALUFlags[NSTICKY-1:0];
        end
    end

    // IT sequencer next-state: flush aborts, stall freezes, each accepted instruction uses a slot.
    always_comb begin
        state_d  = state_q;
        itcond_d = itcond_q;
        mask_d   = mask_q;
        remain_d = ITRemain;
        iterr_d  = 1'b0;
        if (Flush) begin
            state_d  = IDLE;
            remain_d = 3'd0;
            mask_d   = '0;
        end else if (accept) begin
            case (state_q)
                IDLE: begin
                    if (ITStart) begin
                        if (len_ok) begin
                            state_d  = ACTIVE;
                            itcond_d = ITCond;
                            mask_d   = ITMask;
                            remain_d = ITLen;
                        end else begin
                            iterr_d = 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    if (ITRemain != 3'd0) begin
                        remain_d = ITRemain - 3'd1;
                        mask_d   = mask_q >> 1;
                    end
                    if (ITRemain <= 3'd1) begin
                        state_d = IDLE;
                    end
                    if (ITStart) begin
                        iterr_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            itcond_q <= 4'd0;
            mask_q   <= '0;
            ITRemain <= 3'd0;
            ITErr    <= 1'b0;
        end else begin
            state_q  <= state_d;
            itcond_q <= itcond_d;
            mask_q   <= mask_d;
            ITRemain <= remain_d;
            ITErr    <= iterr_d;
        end
    end

    // Architectural flags register; stall freezes it regardless of CondEx.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Flags <= '0;
        end else if (!Stall) begin
            Flags <= FlagsNext;
        end
    end

endmodule

// File: tb/tb_cond_flags_unit.sv
// Self-checking bench for cond_flags_unit: condition/flag vector table plus IT-block sequences.
module tb_cond_flags_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       Stall, Flush, Valid;
    logic [3:0] Cond;
    logic [4:0] ALUFlags;
    logic [2:0] FlagsWrite;
    logic       ITStart;
    logic [3:0] ITCond;
    logic [3:0] ITMask;
    logic [2:0] ITLen;
    logic       CondEx;
    logic [4:0] FlagsNext;
    logic [4:0] Flags;
    logic       InIT;
    logic [2:0] ITRemain;
    logic       ITErr;

    int total = 0;
    int bad   = 0;
    logic [4:0] exp_q[$];

    cond_flags_unit #(.NFLAGS(5), .IT_MAX(4)) dut (
        .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush), .Valid(Valid),
        .Cond(Cond), .ALUFlags(ALUFlags), .FlagsWrite(FlagsWrite),
        .ITStart(ITStart), .ITCond(ITCond), .ITMask(ITMask), .ITLen(ITLen),
        .CondEx(CondEx), .FlagsNext(FlagsNext), .Flags(Flags), .InIT(InIT),
        .ITRemain(ITRemain), .ITErr(ITErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] cond;
        logic [2:0] fw;
        logic [4:0] alu;
        logic       valid;
        logic       exp_cx;
        logic [4:0] exp_flags;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Drive one cycle of inputs just after the falling edge.
    task automatic drive(input logic v, input logic st, input logic fl, input logic [3:0] c,
                         input logic [2:0] fw, input logic [4:0] alu, input logic its,
                         input logic [3:0] itc, input logic [3:0] itm, input logic [2:0] itl);
        @(negedge clk);
        Valid = v; Stall = st; Flush = fl; Cond = c; FlagsWrite = fw; ALUFlags = alu;
        ITStart = its; ITCond = itc; ITMask = itm; ITLen = itl;
        #1;
    endtask

    // Queue the expected flags, cross the rising edge, then compare registered outputs.
    task automatic step(input string name, input logic [4:0] ef, input logic [2:0] erem,
                        input logic einit, input logic eerr);
        logic [4:0] want;
        exp_q.push_back(ef);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({name, "_queue"}, 32'd0, 32'd1);
        end else begin
            want = exp_q.pop_front();
            check({name, "_flags"}, 32'(Flags), 32'(want));
        end
        check({name, "_remain"}, 32'(ITRemain), 32'(erem));
        check({name, "_init"}, 32'(InIT), 32'(einit));
        check({name, "_iterr"}, 32'(ITErr), 32'(eerr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //           cond   fw      alu       v     cx    flags
        vecs[0]  = '{4'd14, 3'b111, 5'b01000, 1'b1, 1'b1, 5'b01000};
        vecs[1]  = '{4'd1,  3'b110, 5'b10101, 1'b1, 1'b0, 5'b01000};
        vecs[2]  = '{4'd0,  3'b110, 5'b10101, 1'b1, 1'b1, 5'b10100};
        vecs[3]  = '{4'd4,  3'b111, 5'b00001, 1'b1, 1'b1, 5'b00001};
        vecs[4]  = '{4'd14, 3'b001, 5'b00000, 1'b1, 1'b1, 5'b00001};
        vecs[5]  = '{4'd15, 3'b111, 5'b11110, 1'b1, 1'b0, 5'b00001};
        vecs[6]  = '{4'd14, 3'b111, 5'b11110, 1'b0, 1'b0, 5'b00001};
        vecs[7]  = '{4'd5,  3'b010, 5'b00110, 1'b1, 1'b1, 5'b00111};
        vecs[8]  = '{4'd6,  3'b000, 5'b11111, 1'b1, 1'b1, 5'b00111};
        vecs[9]  = '{4'd10, 3'b111, 5'b11111, 1'b1, 1'b0, 5'b00111};
        vecs[10] = '{4'd11, 3'b100, 5'b01000, 1'b1, 1'b1, 5'b01111};
        vecs[11] = '{4'd8,  3'b111, 5'b10000, 1'b1, 1'b0, 5'b01111};
        vecs[12] = '{4'd9,  3'b111, 5'b10000, 1'b1, 1'b1, 5'b10001};
        vecs[13] = '{4'd12, 3'b111, 5'b01110, 1'b1, 1'b0, 5'b10001};
        vecs[14] = '{4'd13, 3'b011, 5'b00010, 1'b1, 1'b1, 5'b10011};
        vecs[15] = '{4'd10, 3'b000, 5'b00000, 1'b1, 1'b1, 5'b10011};
        vecs[16] = '{4'd3,  3'b100, 5'b01000, 1'b1, 1'b1, 5'b01011};
        vecs[17] = '{4'd7,  3'b111, 5'b00000, 1'b1, 1'b0, 5'b01011};
        vecs[18] = '{4'd2,  3'b111, 5'b00000, 1'b1, 1'b0, 5'b01011};

        reset = 1'b1;
        Valid = 1'b0; Stall = 1'b0; Flush = 1'b0; Cond = 4'd14; FlagsWrite = 3'b000;
        ALUFlags = 5'b0; ITStart = 1'b0; ITCond = 4'd0; ITMask = 4'd0; ITLen = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_flags", 32'(Flags), 32'd0);
        check("rst_init", 32'(InIT), 32'd0);
        check("rst_remain", 32'(ITRemain), 32'd0);
        check("rst_iterr", 32'(ITErr), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Condition and grouped flag-write table.
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].valid, 1'b0, 1'b0, vecs[i].cond, vecs[i].fw, vecs[i].alu,
                  1'b0, 4'd0, 4'd0, 3'd0);
            check($sformatf("vec%0d_condex", i), 32'(CondEx), 32'(vecs[i].exp_cx));
            step($sformatf("vec%0d", i), vecs[i].exp_flags, 3'd0, 1'b0, 1'b0);
        end

        // IT EQ, len 3, mask 0101 with Z=1: slots execute 1,0,1; Cond field ignored.
        drive(1'b1, 1'b0, 1'b0, 4'd14, 3'b000, 5'b0, 1'b1, 4'd0, 4'b0101, 3'd3);
        step("it_start", 5'b01011, 3'd3, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 4'd15, 3'b000, 5'b0, 1'b0, 4'd0, 4'd0, 3'd0);
        check("it_slot1_condex", 32'(CondEx), 32'd1);
        step("it_slot1", 5'b01011, 3'd2, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 4'd15, 3'b000, 5'b0, 1'b0, 4'd0, 4'd0, 3'd0);
        check("it_slot2_condex", 32'(CondEx), 32'd0);
        step("it_slot2", 5'b01011, 3'd1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 4'd15, 3'b000, 5'b0, 1'b0, 4'd0, 4'd0, 3'd0);
        check("it_slot3_condex", 32'(CondEx), 32'd1);
        step("it_slot3", 5'b01011, 3'd0, 1'b0, 1'b0);

        // Stall for two cycles inside slot 2 with a pending flag write.
        drive(1'b1, 1'b0, 1'b0, 4'd14, 3'b000, 5'b0, 1'b1, 4'd0, 4'b0111, 3'd3);
        step("st_start", 5'b01011, 3'd3, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 4'd14, 3'b000, 5'b0, 1'b0, 4'd0, 4'd0, 3'd0);
        step("st_slot1", 5'b01011, 3'd2, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b1, 1'b0, 4'd14, 3'b111, 5'b10000, 1'b0, 4'd0, 4'd0, 3'd0);
            check($sformatf("st_hold%0d_condex", k), 32'(CondEx), 32'd1);
            step($sformatf("st_hold%0d", k), 5'b01011, 3'd2, 1'b1, 1'b0);
        end
        drive(1'b1, 1'b0, 1'b0, 4'd14, 3'b000, 5'b0, 1'b0, 4'd0, 4'd0, 3'd0);
        check("st_slot2_condex", 32'(CondEx), 32'd1);
        step("st_slot2", 5'b01011, 3'd1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 4'd14, 3'b000, 5'b0, 1'b0, 4'd0, 4'd0, 3'd0);
        step("st_slot3", 5'b01011, 3'd0, 1'b0, 1'b0);

        // Flush during slot 2 of a 4-slot block.
        drive(1'b1, 1'b0, 1'b0, 4'd14, 3'b000, 5'b0, 1'b1, 4'd0, 4'b1111, 3'd4);
        step("fl_start", 5'b01011, 3'd4, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 4'd14, 3'b000, 5'b0, 1'b0, 4'd0, 4'd0, 3'd0);
        step("fl_slot1", 5'b01011, 3'd3, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 4'd14, 3'b111, 5'b10000, 1'b0, 4'd0, 4'd0, 3'd0);
        check("fl_slot2_condex", 32'(CondEx), 32'd0);
        step("fl_slot2", 5'b01011, 3'd0, 1'b0, 1'b0);

        // Illegal lengths pulse ITErr for exactly one cycle.
        drive(1'b1, 1'b0, 1'b0, 4'd14, 3'b000, 5'b0, 1'b1, 4'd0, 4'b0001, 3'd0);
        step("err_len0", 5'b01011, 3'd0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 4'd14, 3'b000, 5'b0, 1'b0, 4'd0, 4'd0, 3'd0);
        step("err_len0_after", 5'b01011, 3'd0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 4'd14, 3'b000, 5'b0, 1'b1, 4'd0, 4'b1111, 3'd5);
        step("err_len5", 5'b01011, 3'd0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 4'd14, 3'b000, 5'b0, 1'b1, 4'd0, 4'b0001, 3'd0);
        step("err_stalled", 5'b01011, 3'd0, 1'b0, 1'b0);

        // Nested IT consumes its slot without reloading.
        drive(1'b1, 1'b0, 1'b0, 4'd14, 3'b000, 5'b0, 1'b1, 4'd0, 4'b0011, 3'd2);
        step("nest_start", 5'b01011, 3'd2, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 4'd14, 3'b000, 5'b0, 1'b1, 4'd1, 4'b1111, 3'd3);
        step("nest_slot1", 5'b01011, 3'd1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 4'd14, 3'b000, 5'b0, 1'b0, 4'd0, 4'd0, 3'd0);
        step("nest_slot2", 5'b01011, 3'd0, 1'b0, 1'b0);

        // Asynchronous reset with two slots left.
        drive(1'b1, 1'b0, 1'b0, 4'd14, 3'b000, 5'b0, 1'b1, 4'd0, 4'b0111, 3'd3);
        step("ar_start", 5'b01011, 3'd3, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 4'd14, 3'b000, 5'b0, 1'b0, 4'd0, 4'd0, 3'd0);
        step("ar_slot1", 5'b01011, 3'd2, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("ar_flags", 32'(Flags), 32'd0);
        check("ar_init", 32'(InIT), 32'd0);
        check("ar_remain", 32'(ITRemain), 32'd0);
        check("ar_iterr", 32'(ITErr), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        Valid = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
